// File: rtl/io_trap_ctrl.sv
//------------------------------------------------------------------------------
// io_trap_ctrl : Z80 I/O trap logger with NMI; optional macro TRAP_READ_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module io_trap_ctrl #(
  parameter logic [7:0]  CTRL_PORT  = 8'h30,
  parameter logic [7:0]  TRAP_BASE  = 8'hA0,
  parameter logic [7:0]  TRAP_MASK  = 8'hF0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       m1_n,
  output logic       trap_hit,
  output logic       nmi_n
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

`ifdef TRAP_READ_EN
  localparam logic READ_TRAP = 1'b1;
`else
  localparam logic READ_TRAP = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic        enable_q, enable_d;
  logic        overflow_q, overflow_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;

  logic [7:0]  log_addr_q [FIFO_DEPTH];
  logic [7:0]  log_data_q [FIFO_DEPTH];
  logic        log_dir_q  [FIFO_DEPTH];

  logic        io_cyc, ctrl_hit, trp, trp_rd;
  logic        start_evt, ctrl_wr, push_req, push_ok, pop, clr;
  logic [PW:0] count;
  logic [3:0]  count4;
  logic [2:0]  count_sat;
  logic        empty, full;
  logic [7:0]  status, ctrl_rdata, head_addr, head_data;
  logic        head_dir;

  assign io_cyc   = !iorq_n && m1_n && (!rd_n || !wr_n);
  assign ctrl_hit = io_cyc && (addr[7:2] == CTRL_PORT[7:2]);
  assign trp      = io_cyc && enable_q && ((addr & TRAP_MASK) == TRAP_BASE) && !ctrl_hit;
  assign trp_rd   = READ_TRAP && trp && !rd_n;

  assign trap_hit = ctrl_hit || (trp && !wr_n) || trp_rd;
  assign data_oe  = (ctrl_hit && !rd_n) || trp_rd;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign count4    = 4'(count);
  assign count_sat = count4[3] ? 3'd7 : count4[2:0];
  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign status    = {1'b0, count_sat, overflow_q, full, empty, enable_q};

  assign head_addr = log_addr_q[rd_ptr_q[PW-1:0]];
  assign head_data = log_data_q[rd_ptr_q[PW-1:0]];
  assign head_dir  = log_dir_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    ctrl_rdata = 8'h00;
    case (addr[1:0])
      2'd0:    ctrl_rdata = status;
      2'd1:    ctrl_rdata = empty ? 8'h00 : head_addr;
      2'd2:    ctrl_rdata = empty ? 8'h00 : head_data;
      default: ctrl_rdata = {7'b0, !empty && head_dir};
    endcase
  end

  always_comb begin
    data_out = 8'h00;
    if (ctrl_hit && !rd_n)
      data_out = ctrl_rdata;
    else if (trp_rd)
      data_out = shadow_q;
  end

  // Cycle FSM: one action per I/O cycle on the IDLE->START edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (io_cyc) state_d = S_START;
      S_START: state_d = iorq_n ? S_IDLE : S_HOLD;
      S_HOLD:  if (iorq_n) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_evt = (state_q == S_IDLE) && io_cyc;
    ctrl_wr   = start_evt && ctrl_hit && !wr_n;
    push_req  = start_evt && trp && (!wr_n || trp_rd);
    pop       = start_evt && ctrl_hit && !rd_n && (addr[1:0] == 2'd3) && !empty;
    clr       = ctrl_wr && (addr[1:0] == 2'd0) && data_in[1];
    push_ok   = push_req && !full && !clr;
  end

  always_comb begin
    enable_d   = enable_q;
    overflow_d = overflow_q;
    nmi_pend_d = nmi_pend_q;
    shadow_d   = shadow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (ctrl_wr && addr[1:0] == 2'd0) begin
      enable_d = data_in[0];
      if (data_in[2]) nmi_pend_d = 1'b0;
    end
    if (ctrl_wr && addr[1:0] == 2'd2) shadow_d = data_in;
    // A dropped push still requests service so the handler sees the overflow.
    if (push_req) begin
      nmi_pend_d = 1'b1;
      if (full) overflow_d = 1'b1;
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      shadow_q   <= 8'hFF;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      nmi_n      <= 1'b1;
    end else begin
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      nmi_pend_q <= nmi_pend_d;
      shadow_q   <= shadow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      nmi_n      <= ~nmi_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      log_addr_q[wr_ptr_q[PW-1:0]] <= addr;
      log_data_q[wr_ptr_q[PW-1:0]] <= wr_n ? 8'h00 : data_in;
      log_dir_q[wr_ptr_q[PW-1:0]]  <= !wr_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_trap_ctrl.sv
//------------------------------------------------------------------------------
// tb_io_trap_ctrl : directed Z80 I/O cycles against io_trap_ctrl.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_trap_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe;
  logic       iorq_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       m1_n = 1'b1;
  logic       trap_hit;
  logic       nmi_n;

  int n_chk = 0;
  int n_bad = 0;
  logic last_hit, last_oe;
  logic [7:0] last_rd;

  always #5 clk = ~clk;

  io_trap_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .m1_n     (m1_n),
    .trap_hit (trap_hit),
    .nmi_n    (nmi_n)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Bus outputs are sampled just after the strobes assert, before the first edge.
  task automatic bus(input logic [7:0] a, input logic rd, input logic wr,
                     input logic [7:0] d, input int waits, input logic m1);
    @(negedge clk);
    addr = a; data_in = d; m1_n = m1; iorq_n = 1'b0;
    rd_n = ~rd; wr_n = ~wr;
    #2;
    last_rd = data_out; last_oe = data_oe; last_hit = trap_hit;
    repeat (2 + waits) @(posedge clk);
    @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic out_io(input logic [7:0] a, input logic [7:0] d, input int waits = 0);
    bus(a, 1'b0, 1'b1, d, waits, 1'b1);
  endtask

  task automatic in_io(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus(a, 1'b1, 1'b0, 8'h00, 0, 1'b1);
    chk(tag, last_rd, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nmi", {7'b0, nmi_n}, 8'h01);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_oe_hit", {6'b0, data_oe, trap_hit}, 8'h00);
    @(negedge clk) reset = 1'b0;

    // Enable, one trapped OUT, read it back and pop
    out_io(8'h30, 8'h01);
    chk("ctrl_hit", {7'b0, last_hit}, 8'h01);
    out_io(8'hA5, 8'h5A);
    chk("trap_hit_out", {7'b0, last_hit}, 8'h01);
    chk("nmi_low", {7'b0, nmi_n}, 8'h00);
    in_io("stat1", 8'h30, 8'h11);
    chk("ctrl_oe", {7'b0, last_oe}, 8'h01);
    in_io("head_addr", 8'h31, 8'hA5);
    in_io("head_data", 8'h32, 8'h5A);
    in_io("head_dir", 8'h33, 8'h01);
    in_io("stat_popped", 8'h30, 8'h03);
    chk("nmi_held", {7'b0, nmi_n}, 8'h00);
    out_io(8'h30, 8'h04);
    chk("nmi_ack", {7'b0, nmi_n}, 8'h01);
    in_io("stat_dis", 8'h30, 8'h02);

    // Overflow: five pushes into four entries
    out_io(8'h30, 8'h01);
    for (int i = 0; i < 5; i++) out_io(8'hA0 + 8'(i), 8'h10 + 8'(i));
    in_io("stat_full", 8'h30, 8'h4D);
    chk("nmi_ovf", {7'b0, nmi_n}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      in_io("ent_addr", 8'h31, 8'hA0 + 8'(i));
      in_io("ent_data", 8'h32, 8'h10 + 8'(i));
      in_io("ent_dir", 8'h33, 8'h01);
    end
    in_io("stat_drained", 8'h30, 8'h0B);
    in_io("empty_addr", 8'h31, 8'h00);
    out_io(8'h30, 8'h07);
    in_io("stat_clr", 8'h30, 8'h03);
    chk("nmi_clr", {7'b0, nmi_n}, 8'h01);

    // Out-of-range OUT and interrupt acknowledge are ignored
    out_io(8'hB0, 8'h99);
    chk("miss_hit", {7'b0, last_hit}, 8'h00);
    bus(8'hA1, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    chk("intack_hit", {7'b0, last_hit}, 8'h00);
    bus(8'hA1, 1'b0, 1'b1, 8'h55, 0, 1'b0);
    chk("m1wr_hit", {7'b0, last_hit}, 8'h00);
    in_io("stat_ign", 8'h30, 8'h03);
    chk("nmi_ign", {7'b0, nmi_n}, 8'h01);
`ifndef TRAP_READ_EN
    bus(8'hA3, 1'b1, 1'b0, 8'h00, 0, 1'b1);
    chk("rdpass_hit_oe", {6'b0, last_oe, last_hit}, 8'h00);
    in_io("stat_rdpass", 8'h30, 8'h03);
`endif

    // Wait states log once; reset mid-cycle
    out_io(8'hA1, 8'hC3, 3);
    in_io("stat_wait", 8'h30, 8'h11);
    in_io("wait_data", 8'h32, 8'hC3);
    @(negedge clk);
    addr = 8'hA1; data_in = 8'hEE; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_hit", {7'b0, trap_hit}, 8'h00);
    chk("rst_mid_nmi", {7'b0, nmi_n}, 8'h01);
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk) reset = 1'b0;
    in_io("stat_rst", 8'h30, 8'h02);
    in_io("rst_empty", 8'h31, 8'h00);

    // Trapped IN cycle
    out_io(8'h30, 8'h01);
    out_io(8'h32, 8'h77);
    bus(8'hA2, 1'b1, 1'b0, 8'h00, 0, 1'b1);
`ifdef TRAP_READ_EN
    chk("rdtrap_hit_oe", {6'b0, last_oe, last_hit}, 8'h03);
    chk("rdtrap_bus", last_rd, 8'h77);
    in_io("rd_stat", 8'h30, 8'h11);
    in_io("rd_addr", 8'h31, 8'hA2);
    in_io("rd_data", 8'h32, 8'h00);
    in_io("rd_dir", 8'h33, 8'h00);
    chk("rd_nmi", {7'b0, nmi_n}, 8'h00);
`else
    chk("rdfree_hit_oe", {6'b0, last_oe, last_hit}, 8'h00);
    in_io("rdfree_stat", 8'h30, 8'h03);
    chk("rdfree_nmi", {7'b0, nmi_n}, 8'h01);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
